vga_fb_arbiter: RTL and testbench

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_fb_arbiter.sv | 108 ++++++++++
 tb/tb_vga_fb_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: one memory port shared by a video reader, which
// has priority, and a writer that is starvation-protected by a wait counter.
// Dropped video reads are counted in a saturating 8-bit counter.
module vga_fb_arbiter #(
    parameter int          AW       = 19,
    parameter int          DW       = 8,
    parameter logic [9:0]  MAX_WAIT = 10'd64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    output logic          vid_drop,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [7:0]    drop_cnt
);

    // Encoding chosen so bit 0 is the memory strobe and bit 1 the write
    // enable: mem_en/mem_we come straight from state flops.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_VID  = 2'b01,
        S_WR   = 2'b11
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [9:0] wait_cnt;
    logic       force_wr;
    logic       grant_vid;
    logic       grant_wr;
    logic       rd_pend;

    assign force_wr  = (wait_cnt == MAX_WAIT);
    assign mem_en    = state[0];
    assign mem_we    = state[1];
    // Read data is passed through from memory in the cycle it is valid.
    assign vid_data  = vid_valid ? mem_rdata : '0;

    // Arbitration: video wins unless the writer has waited MAX_WAIT cycles;
    // a write being acknowledged this cycle is not requested again.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        grant_wr   = 1'b0;
        grant_vid  = 1'b0;
        state_next = S_IDLE;
        if (wr_req && !wr_ack && (!vid_req || force_wr)) begin
            grant_wr   = 1'b1;
            state_next = S_WR;
        end else if (vid_req) begin
            grant_vid  = 1'b1;
            state_next = S_VID;
        end
    end

    // Last-grant state register; it directly drives mem_en / mem_we.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Memory address/data, handshake pulses and read pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            wr_ack    <= 1'b0;
            rd_pend   <= 1'b0;
            vid_valid <= 1'b0;
            vid_drop  <= 1'b0;
        end else begin
            wr_ack    <= grant_wr;
            rd_pend   <= grant_vid;
            vid_valid <= rd_pend;
            vid_drop  <= grant_wr && vid_req;
            if (grant_wr) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end else if (grant_vid) begin
                mem_addr  <= vid_addr;
            end
        end
    end

    // Writer starvation counter: counts ungranted request cycles, saturating.
    always_ff @(posedge clk) begin
        if (rst || !wr_req || grant_wr) wait_cnt <= '0;
        else if (!force_wr)             wait_cnt <= wait_cnt + 10'd1;
    end

    // Saturating count of pre-empted video reads, stepped with vid_drop.
    always_ff @(posedge clk) begin
        if (rst)                                             drop_cnt <= '0;
        else if (grant_wr && vid_req && drop_cnt != 8'hFF)   drop_cnt <= drop_cnt + 8'd1;
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: a per-cycle vector table for streaming,
// idle write and contention, plus sequences for starvation, drop-counter
// saturation and reset in the middle of a read.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        vid_req;
    logic [18:0] vid_addr;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic        vid_drop;
    logic        wr_req;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        mem_en;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    vga_fb_arbiter dut (
        .clk(clk), .rst(rst),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
        .vid_valid(vid_valid), .vid_drop(vid_drop),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: read data is address low byte + 0x10, one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem_addr[7:0] + 8'h10;
    end

    typedef struct {
        logic        vr;
        logic [18:0] va;
        logic        wq;
        logic [18:0] wa;
        logic [7:0]  wd;
        logic        en;
        logic        we;
        logic [18:0] addr;
        logic [7:0]  wdat;
        logic        ack;
        logic        vv;
        logic [7:0]  vd;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_en"},    32'(mem_en),    32'd0);
        check({tag, " mem_we"},    32'(mem_we),    32'd0);
        check({tag, " mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, " mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, " vid_valid"}, 32'(vid_valid), 32'd0);
        check({tag, " vid_drop"},  32'(vid_drop),  32'd0);
        check({tag, " vid_data"},  32'(vid_data),  32'd0);
        check({tag, " wr_ack"},    32'(wr_ack),    32'd0);
        check({tag, " drop_cnt"},  32'(drop_cnt),  32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int waited;
        bit timed_out;

        //             vr    va      wq    wa        wd       en    we    addr      wdat     ack   vv    vd
        vecs[0]  = '{1'b1, 19'h0, 1'b0, 19'h0,   8'h00, 1'b1, 1'b0, 19'h0,   8'h00, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 19'h1, 1'b0, 19'h0,   8'h00, 1'b1, 1'b0, 19'h1,   8'h00, 1'b0, 1'b1, 8'h10};
        vecs[2]  = '{1'b1, 19'h2, 1'b0, 19'h0,   8'h00, 1'b1, 1'b0, 19'h2,   8'h00, 1'b0, 1'b1, 8'h11};
        vecs[3]  = '{1'b1, 19'h3, 1'b0, 19'h0,   8'h00, 1'b1, 1'b0, 19'h3,   8'h00, 1'b0, 1'b1, 8'h12};
        vecs[4]  = '{1'b0, 19'h0, 1'b0, 19'h0,   8'h00, 1'b0, 1'b0, 19'h3,   8'h00, 1'b0, 1'b1, 8'h13};
        vecs[5]  = '{1'b0, 19'h0, 1'b0, 19'h0,   8'h00, 1'b0, 1'b0, 19'h3,   8'h00, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 19'h0, 1'b1, 19'h100, 8'hAB, 1'b1, 1'b1, 19'h100, 8'hAB, 1'b1, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 19'h0, 1'b1, 19'h100, 8'hAB, 1'b0, 1'b0, 19'h100, 8'hAB, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 19'h0, 1'b0, 19'h0,   8'h00, 1'b0, 1'b0, 19'h100, 8'hAB, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{1'b1, 19'h4, 1'b1, 19'h200, 8'h5C, 1'b1, 1'b0, 19'h4,   8'hAB, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{1'b1, 19'h5, 1'b1, 19'h200, 8'h5C, 1'b1, 1'b0, 19'h5,   8'hAB, 1'b0, 1'b1, 8'h14};
        vecs[11] = '{1'b1, 19'h6, 1'b1, 19'h200, 8'h5C, 1'b1, 1'b0, 19'h6,   8'hAB, 1'b0, 1'b1, 8'h15};
        vecs[12] = '{1'b0, 19'h0, 1'b1, 19'h200, 8'h5C, 1'b1, 1'b1, 19'h200, 8'h5C, 1'b1, 1'b1, 8'h16};
        vecs[13] = '{1'b0, 19'h0, 1'b0, 19'h0,   8'h00, 1'b0, 1'b0, 19'h200, 8'h5C, 1'b0, 1'b0, 8'h00};

        rst = 1'b1; vid_req = 1'b0; vid_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        #1;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;

        // Vector table: stream, idle write with late drop, contention.
        for (int i = 0; i < 14; i++) begin
            vid_req = vecs[i].vr; vid_addr = vecs[i].va;
            wr_req  = vecs[i].wq; wr_addr  = vecs[i].wa; wr_data = vecs[i].wd;
            step();
            check($sformatf("row%0d mem_en", i),    32'(mem_en),    32'(vecs[i].en));
            check($sformatf("row%0d mem_we", i),    32'(mem_we),    32'(vecs[i].we));
            check($sformatf("row%0d mem_addr", i),  32'(mem_addr),  32'(vecs[i].addr));
            check($sformatf("row%0d mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].wdat));
            check($sformatf("row%0d wr_ack", i),    32'(wr_ack),    32'(vecs[i].ack));
            check($sformatf("row%0d vid_valid", i), 32'(vid_valid), 32'(vecs[i].vv));
            check($sformatf("row%0d vid_data", i),  32'(vid_data),  32'(vecs[i].vd));
            check($sformatf("row%0d vid_drop", i),  32'(vid_drop),  32'd0);
        end

        // Starvation: continuous video, writer forced in after 64 waiting cycles.
        vid_req = 1'b1; vid_addr = 19'h7;
        wr_req  = 1'b1; wr_addr  = 19'h300; wr_data = 8'h77;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (!(mem_en && !mem_we) || wr_ack || vid_drop) bad++;
        end
        check("starve reads before force", 32'(bad), 32'd0);
        step();
        check("starve mem_we",    32'(mem_we),    32'd1);
        check("starve mem_addr",  32'(mem_addr),  32'h300);
        check("starve mem_wdata", 32'(mem_wdata), 32'h77);
        check("starve wr_ack",    32'(wr_ack),    32'd1);
        check("starve vid_drop",  32'(vid_drop),  32'd1);
        check("starve drop_cnt",  32'(drop_cnt),  32'd1);
        step();
        check("resume mem_en",    32'(mem_en),    32'd1);
        check("resume mem_we",    32'(mem_we),    32'd0);
        check("resume vid_drop",  32'(vid_drop),  32'd0);
        check("resume wr_ack",    32'(wr_ack),    32'd0);
        check("dropped no valid", 32'(vid_valid), 32'd0);
        check("resume drop_cnt",  32'(drop_cnt),  32'd1);
        wr_req = 1'b0;
        step();
        check("resume vid_valid", 32'(vid_valid), 32'd1);
        check("resume vid_data",  32'(vid_data),  32'h17);

        // Saturation: 300 more forced writes against continuous video.
        timed_out = 1'b0;
        for (int k = 0; k < 300 && !timed_out; k++) begin
            wr_req = 1'b1;
            waited = 0;
            while (!wr_ack && waited < 80) begin
                step();
                waited++;
            end
            if (!wr_ack) begin
                timed_out = 1'b1;
                check("saturate wr_ack timeout", 32'(wr_ack), 32'd1);
            end
            wr_req = 1'b0;
            step();
        end
        vid_req = 1'b0;
        step();
        check("saturate drop_cnt", 32'(drop_cnt), 32'hFF);

        // Reset one cycle after a video grant cancels the read.
        step();
        vid_req = 1'b1; vid_addr = 19'h9;
        step();
        check("pre-reset read strobe", 32'(mem_en), 32'd1);
        vid_req = 1'b0; rst = 1'b1;
        step();
        check_all_zero("midreset");
        rst = 1'b0;
        step();
        check("post-reset no valid", 32'(vid_valid), 32'd0);
        check("post-reset mem_en",   32'(mem_en),    32'd0);
        vid_req = 1'b1; vid_addr = 19'h2;
        step();
        check("post-reset read en",   32'(mem_en),   32'd1);
        check("post-reset read addr", 32'(mem_addr), 32'h2);
        vid_req = 1'b0;
        step();
        check("post-reset vid_valid", 32'(vid_valid), 32'd1);
        check("post-reset vid_data",  32'(vid_data),  32'h12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
